// File: rtl/qspi_flash_sequencer_if.sv
// rtl/qspi_flash_sequencer_if.sv - host request/response and qspi_master command bundle for the flash sequencer
interface qspi_flash_sequencer_if;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [23:0] op_addr;
  logic [31:0] op_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  m_clk_div;
  logic        m_wr;
  logic        m_rd;
  logic        m_quad;
  logic [7:0]  m_cmd;
  logic [5:0]  m_cmd_len;
  logic [23:0] m_addr;
  logic [5:0]  m_addr_len;
  logic [15:0] m_dummy_len;
  logic [15:0] m_data_len;
  logic [31:0] m_tx_bits;
  logic        m_tx_done;
  logic        m_rx_done;
  logic [31:0] m_rx_bits;

  // Sequencer side: serves host requests, drives qspi_master transactions.
  modport slave (
    input  op_valid, op_code, op_addr, op_wdata, m_tx_done, m_rx_done, m_rx_bits,
    output op_ready, resp_valid, resp_rdata, resp_err, m_clk_div, m_wr, m_rd, m_quad,
           m_cmd, m_cmd_len, m_addr, m_addr_len, m_dummy_len, m_data_len, m_tx_bits
  );

  // Environment side: host plus qspi_master completion path.
  modport master (
    output op_valid, op_code, op_addr, op_wdata, m_tx_done, m_rx_done, m_rx_bits,
    input  op_ready, resp_valid, resp_rdata, resp_err, m_clk_div, m_wr, m_rd, m_quad,
           m_cmd, m_cmd_len, m_addr, m_addr_len, m_dummy_len, m_data_len, m_tx_bits
  );
endinterface

// File: rtl/qspi_flash_sequencer.sv
// rtl/qspi_flash_sequencer.sv - flash op sequencer (WREN/cmd/WIP poll); QSPI_QUAD_IO_EN selects quad read/program
module qspi_flash_sequencer #(
  parameter logic [7:0]  CLK_DIV   = 8'd1,
  parameter logic [15:0] DUMMY_CYC = 16'd8,
  parameter logic [19:0] POLL_MAX  = 20'hFFFFF
) (
  input  logic                   clock,
  input  logic                   reset,
  qspi_flash_sequencer_if.slave  bus
);

  localparam logic [1:0] OP_READ   = 2'd0;
  localparam logic [1:0] OP_PROG   = 2'd1;
  localparam logic [1:0] OP_ERASE  = 2'd2;
  localparam logic [1:0] OP_STATUS = 2'd3;

`ifdef QSPI_QUAD_IO_EN
  localparam logic [7:0] CMD_READ  = 8'h6B;
  localparam logic [7:0] CMD_PROG  = 8'h32;
  localparam logic       QUAD_DATA = 1'b1;
`else
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_PROG  = 8'h02;
  localparam logic       QUAD_DATA = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WREN, S_WREN_W, S_CMD, S_CMD_W, S_POLL, S_POLL_W, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [19:0] poll_q, poll_d;
  logic        read_type;

  assign read_type = (op_q == OP_READ) || (op_q == OP_STATUS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      addr_q  <= 24'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      poll_q  <= 20'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      poll_q  <= poll_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    poll_d  = poll_q;
    case (state_q)
      S_IDLE: begin
        if (bus.op_valid) begin
          op_d    = bus.op_code;
          addr_d  = bus.op_addr;
          wdata_d = bus.op_wdata;
          rdata_d = 32'd0;
          err_d   = 1'b0;
          poll_d  = 20'd0;
          state_d = (bus.op_code == OP_PROG || bus.op_code == OP_ERASE) ? S_WREN : S_CMD;
        end
      end
      S_WREN:   state_d = S_WREN_W;
      S_WREN_W: if (bus.m_tx_done) state_d = S_CMD;
      S_CMD:    state_d = S_CMD_W;
      S_CMD_W: begin
        // Only the completion kind matching the issued transaction advances.
        if (read_type) begin
          if (bus.m_rx_done) begin
            rdata_d = (op_q == OP_READ) ? bus.m_rx_bits : {24'd0, bus.m_rx_bits[7:0]};
            state_d = S_RESP;
          end
        end else if (bus.m_tx_done) begin
          state_d = S_POLL;
        end
      end
      S_POLL:   state_d = S_POLL_W;
      S_POLL_W: begin
        if (bus.m_rx_done) begin
          if (!bus.m_rx_bits[0]) begin
            state_d = S_RESP;
          end else if (poll_q + 20'd1 >= POLL_MAX) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            poll_d  = poll_q + 20'd1;
            state_d = S_POLL;
          end
        end
      end
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign bus.m_clk_div = CLK_DIV;

  // Command fields derive from the phase pair (issue + wait), so they hold until the done pulse.
  always_comb begin
    bus.op_ready    = (state_q == S_IDLE);
    bus.resp_valid  = (state_q == S_RESP);
    bus.resp_rdata  = (state_q == S_RESP) ? rdata_q : 32'd0;
    bus.resp_err    = (state_q == S_RESP) ? err_q : 1'b0;
    bus.m_wr        = 1'b0;
    bus.m_rd        = 1'b0;
    bus.m_quad      = 1'b0;
    bus.m_cmd       = 8'h00;
    bus.m_cmd_len   = 6'd0;
    bus.m_addr      = 24'd0;
    bus.m_addr_len  = 6'd0;
    bus.m_dummy_len = 16'd0;
    bus.m_data_len  = 16'd0;
    bus.m_tx_bits   = 32'd0;
    case (state_q)
      S_WREN, S_WREN_W: begin
        bus.m_wr      = (state_q == S_WREN);
        bus.m_cmd     = 8'h06;
        bus.m_cmd_len = 6'd8;
      end
      S_CMD, S_CMD_W: begin
        bus.m_cmd_len = 6'd8;
        case (op_q)
          OP_READ: begin
            bus.m_rd        = (state_q == S_CMD);
            bus.m_cmd       = CMD_READ;
            bus.m_quad      = QUAD_DATA;
            bus.m_addr      = addr_q;
            bus.m_addr_len  = 6'd24;
            bus.m_dummy_len = DUMMY_CYC;
            bus.m_data_len  = 16'd32;
          end
          OP_PROG: begin
            bus.m_wr        = (state_q == S_CMD);
            bus.m_cmd       = CMD_PROG;
            bus.m_quad      = QUAD_DATA;
            bus.m_addr      = addr_q;
            bus.m_addr_len  = 6'd24;
            bus.m_data_len  = 16'd32;
            bus.m_tx_bits   = wdata_q;
          end
          OP_ERASE: begin
            bus.m_wr        = (state_q == S_CMD);
            bus.m_cmd       = 8'hD8;
            bus.m_addr      = addr_q;
            bus.m_addr_len  = 6'd24;
          end
          default: begin
            bus.m_rd        = (state_q == S_CMD);
            bus.m_cmd       = 8'h05;
            bus.m_data_len  = 16'd8;
          end
        endcase
      end
      S_POLL, S_POLL_W: begin
        bus.m_rd       = (state_q == S_POLL);
        bus.m_cmd      = 8'h05;
        bus.m_cmd_len  = 6'd8;
        bus.m_data_len = 16'd8;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qspi_flash_sequencer.sv
// tb/tb_qspi_flash_sequencer.sv - directed bench with flash responder, transaction model and per-cycle monitor
`timescale 1ns/1ps
module tb_qspi_flash_sequencer;

  localparam logic [19:0] PMAX = 20'd4;
`ifdef QSPI_QUAD_IO_EN
  localparam logic [7:0] RD_CMD = 8'h6B;
  localparam logic [7:0] PG_CMD = 8'h32;
  localparam logic       QX     = 1'b1;
`else
  localparam logic [7:0] RD_CMD = 8'h0B;
  localparam logic [7:0] PG_CMD = 8'h02;
  localparam logic       QX     = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  qspi_flash_sequencer_if bus();

  qspi_flash_sequencer #(
    .CLK_DIV(8'd1), .DUMMY_CYC(16'd8), .POLL_MAX(PMAX)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic        wr;
    logic        quad;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [5:0]  alen;
    logic [15:0] dummy;
    logic [15:0] dlen;
    logic [31:0] tx;
  } txn_t;

  int total = 0;
  int bad = 0;

  txn_t obs_q[$];
  txn_t exp_q[$];

  logic [1:0]  cur_op;
  logic [7:0]  status_val;
  logic [31:0] read_word;
  int          wip_polls;
  int          polls_seen = 0;
  int          poll_base;
  int          inject_req = 0;
  logic        in_op;
  int          resp_count = 0;
  logic [31:0] got_rdata;
  logic        got_err;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic wr, input logic quad, input logic [7:0] cmd,
                              input logic [23:0] addr, input logic [5:0] alen,
                              input logic [15:0] dummy, input logic [15:0] dlen,
                              input logic [31:0] tx);
    txn_t t;
    t.wr = wr; t.quad = quad; t.cmd = cmd; t.addr = addr; t.alen = alen;
    t.dummy = dummy; t.dlen = dlen; t.tx = tx;
    return t;
  endfunction

  // Flash command sequence an operation must produce, from the datasheet-level rules.
  task automatic build_expected(input logic [1:0] code, input logic [23:0] a, input logic [31:0] d,
                                input int wip, output logic [31:0] e_rdata, output logic e_err);
    int npolls;
    exp_q.delete();
    e_rdata = 32'd0;
    e_err   = 1'b0;
    case (code)
      2'd0: begin
        exp_q.push_back(mk(1'b0, QX, RD_CMD, a, 6'd24, 16'd8, 16'd32, 32'd0));
        e_rdata = read_word;
      end
      2'd3: begin
        exp_q.push_back(mk(1'b0, 1'b0, 8'h05, 24'd0, 6'd0, 16'd0, 16'd8, 32'd0));
        e_rdata = {24'd0, status_val};
      end
      default: begin
        exp_q.push_back(mk(1'b1, 1'b0, 8'h06, 24'd0, 6'd0, 16'd0, 16'd0, 32'd0));
        if (code == 2'd1) exp_q.push_back(mk(1'b1, QX, PG_CMD, a, 6'd24, 16'd0, 16'd32, d));
        else              exp_q.push_back(mk(1'b1, 1'b0, 8'hD8, a, 6'd24, 16'd0, 16'd0, 32'd0));
        npolls = (wip + 1 < int'(PMAX)) ? wip + 1 : int'(PMAX);
        e_err  = (wip >= int'(PMAX));
        for (int i = 0; i < npolls; i++)
          exp_q.push_back(mk(1'b0, 1'b0, 8'h05, 24'd0, 6'd0, 16'd0, 16'd8, 32'd0));
      end
    endcase
  endtask

  // Flash/qspi_master responder: done pulse 3 cycles after each strobe, plus a wrong-kind pulse on writes.
  initial begin : responder
    int   pend = 0;
    logic pend_wr = 1'b0;
    logic [7:0] pend_cmd = 8'h00;
    int   inject_ack = 0;
    txn_t t;
    bus.m_tx_done = 1'b0;
    bus.m_rx_done = 1'b0;
    bus.m_rx_bits = 32'd0;
    forever begin
      @(posedge clock); #1;
      bus.m_tx_done = 1'b0;
      bus.m_rx_done = 1'b0;
      if (reset) begin
        pend = 0;
        continue;
      end
      if (inject_req != inject_ack) begin
        inject_ack = inject_req;
        bus.m_tx_done = 1'b1;
        bus.m_rx_done = 1'b1;
        bus.m_rx_bits = 32'h1;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (pend_wr) bus.m_tx_done = 1'b1;
          else begin
            bus.m_rx_done = 1'b1;
            if (pend_cmd == 8'h05) begin
              if (cur_op == 2'd3) bus.m_rx_bits = {24'd0, status_val};
              else begin
                polls_seen++;
                bus.m_rx_bits = {24'd0, 7'h01, ((polls_seen - poll_base) <= wip_polls)};
              end
            end else bus.m_rx_bits = read_word;
          end
        end else if (pend == 1 && pend_wr) begin
          bus.m_rx_done = 1'b1;
          bus.m_rx_bits = 32'hFFFF_FFFF;
        end
      end
      if (bus.m_wr || bus.m_rd) begin
        t.wr    = bus.m_wr;
        t.quad  = bus.m_quad;
        t.cmd   = bus.m_cmd;
        t.alen  = bus.m_addr_len;
        t.addr  = (bus.m_addr_len != 6'd0) ? bus.m_addr : 24'd0;
        t.dummy = bus.m_dummy_len;
        t.dlen  = bus.m_data_len;
        t.tx    = (bus.m_wr && bus.m_data_len != 16'd0) ? bus.m_tx_bits : 32'd0;
        obs_q.push_back(t);
        pend     = 3;
        pend_wr  = bus.m_wr;
        pend_cmd = bus.m_cmd;
      end
    end
  end

  // Per-cycle protocol monitor: single outstanding strobe, fields held until matching done, one-cycle resp.
  initial begin : monitor
    logic         outst = 1'b0;
    logic         cap_wr = 1'b0;
    logic [127:0] cap = '0;
    logic [127:0] snap;
    logic         prev_resp = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        outst = 1'b0;
        prev_resp = 1'b0;
        continue;
      end
      snap = {19'd0, bus.m_quad, bus.m_cmd, bus.m_cmd_len, bus.m_addr, bus.m_addr_len,
              bus.m_dummy_len, bus.m_data_len, bus.m_tx_bits};
      check("clk_div", bus.m_clk_div, 8'd1);
      check("dual_strobe", bus.m_wr & bus.m_rd, 1'b0);
      if (bus.m_wr || bus.m_rd) begin
        check("strobe_while_outstanding", outst, 1'b0);
        check("cmd_len", bus.m_cmd_len, 6'd8);
        cap    = snap;
        cap_wr = bus.m_wr;
        outst  = 1'b1;
      end else if (outst) begin
        check("field_hold", snap, cap);
        if ((cap_wr && bus.m_tx_done) || (!cap_wr && bus.m_rx_done)) outst = 1'b0;
      end
      if (in_op) check("op_ready_busy", bus.op_ready, 1'b0);
      if (bus.resp_valid) begin
        resp_count++;
        check("resp_one_cycle", prev_resp, 1'b0);
      end
      prev_resp = bus.resp_valid;
    end
  end

  task automatic do_op(input logic [1:0] code, input logic [23:0] a, input logic [31:0] d,
                       input int exp_wait);
    int          waited = 0;
    int          n = 0;
    int          base;
    int          rc0;
    logic [31:0] e_rdata;
    logic        e_err;
    base        = obs_q.size();
    poll_base   = polls_seen;
    cur_op      = code;
    bus.op_code  = code;
    bus.op_addr  = a;
    bus.op_wdata = d;
    bus.op_valid = 1'b1;
    while (!bus.op_ready && waited < 50) begin
      @(posedge clock); #1;
      waited++;
    end
    check("accept_in_time", waited < 50, 1'b1);
    if (exp_wait >= 0) check("accept_wait", waited, exp_wait);
    @(posedge clock); #1;
    bus.op_valid = 1'b0;
    in_op = 1'b1;
    rc0 = resp_count;
    check("first_strobe", bus.m_wr | bus.m_rd, 1'b1);
    check("ready_low_after_accept", bus.op_ready, 1'b0);
    while (!bus.resp_valid && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    check("resp_seen", bus.resp_valid, 1'b1);
    got_rdata = bus.resp_rdata;
    got_err   = bus.resp_err;
    in_op = 1'b0;
    @(negedge clock); #1;
    check("resp_count", resp_count, rc0 + 1);
    build_expected(code, a, d, wip_polls, e_rdata, e_err);
    check("n_txn", obs_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
      check($sformatf("t%0d_kind", i),  obs_q[base+i].wr,    exp_q[i].wr);
      check($sformatf("t%0d_quad", i),  obs_q[base+i].quad,  exp_q[i].quad);
      check($sformatf("t%0d_cmd", i),   obs_q[base+i].cmd,   exp_q[i].cmd);
      check($sformatf("t%0d_addr", i),  obs_q[base+i].addr,  exp_q[i].addr);
      check($sformatf("t%0d_alen", i),  obs_q[base+i].alen,  exp_q[i].alen);
      check($sformatf("t%0d_dummy", i), obs_q[base+i].dummy, exp_q[i].dummy);
      check($sformatf("t%0d_dlen", i),  obs_q[base+i].dlen,  exp_q[i].dlen);
      check($sformatf("t%0d_tx", i),    obs_q[base+i].tx,    exp_q[i].tx);
    end
    check("resp_rdata", got_rdata, e_rdata);
    check("resp_err", got_err, e_err);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin : driver
    int base;
    int n;
    int rc;
    reset        = 1'b1;
    in_op        = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_code  = 2'd0;
    bus.op_addr  = 24'd0;
    bus.op_wdata = 32'd0;
    cur_op       = 2'd0;
    status_val   = 8'h00;
    read_word    = 32'd0;
    wip_polls    = 0;
    poll_base    = 0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_op_ready", bus.op_ready, 1'b1);
    check("rst_m_wr", bus.m_wr, 1'b0);
    check("rst_m_rd", bus.m_rd, 1'b0);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_clk_div", bus.m_clk_div, 8'd1);
    check("rst_m_cmd", bus.m_cmd, 8'h00);
    check("rst_m_quad", bus.m_quad, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;

    status_val = 8'h80;
    do_op(2'd3, 24'h000000, 32'd0, 0);
    check("status_rdata_lit", got_rdata, 32'h0000_0080);

    wip_polls = 3;
    base = obs_q.size();
    do_op(2'd1, 24'h000600, 32'h1234_5678, 1);
    check("prog_txn_lit", obs_q.size() - base, 6);
    check("prog_polls_lit", polls_seen - poll_base, 4);
    check("prog_err_lit", got_err, 1'b0);

    read_word = 32'h1234_5678;
    do_op(2'd0, 24'h000600, 32'd0, 1);
    check("read_rdata_lit", got_rdata, 32'h1234_5678);

    wip_polls = 1000;
    base = obs_q.size();
    do_op(2'd2, 24'h012000, 32'd0, 1);
    check("erase_txn_lit", obs_q.size() - base, 6);
    check("erase_polls_lit", polls_seen - poll_base, 4);
    check("erase_err_lit", got_err, 1'b1);

    rc = resp_count;
    inject_req++;
    repeat (6) begin
      @(posedge clock); #1;
      check("idle_done_no_strobe", bus.m_wr | bus.m_rd, 1'b0);
      check("idle_done_ready", bus.op_ready, 1'b1);
    end
    check("idle_done_no_resp", resp_count, rc);

    wip_polls = 2;
    base = obs_q.size();
    poll_base = polls_seen;
    cur_op = 2'd1;
    bus.op_code  = 2'd1;
    bus.op_addr  = 24'h000700;
    bus.op_wdata = 32'hCAFE_F00D;
    bus.op_valid = 1'b1;
    @(posedge clock); #1;
    bus.op_valid = 1'b0;
    in_op = 1'b1;
    n = 0;
    while (obs_q.size() - base < 2 && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    check("midprog_reached_cmd", obs_q.size() - base >= 2, 1'b1);
    rc = resp_count;
    reset = 1'b1;
    in_op = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      check("rst_mid_strobes", {bus.m_wr, bus.m_rd}, 2'b00);
      check("rst_mid_ready", bus.op_ready, 1'b1);
      check("rst_mid_resp", bus.resp_valid, 1'b0);
    end
    reset = 1'b0;
    repeat (10) begin
      @(posedge clock); #1;
      check("post_rst_idle", {bus.m_wr, bus.m_rd, bus.op_ready}, 3'b001);
    end
    check("post_rst_no_resp", resp_count, rc);

    status_val = 8'h01;
    do_op(2'd3, 24'h000000, 32'd0, 0);
    check("recover_rdata_lit", got_rdata, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
